// File: rtl/seq_det_pkg.sv
// Shared types and default constants for the run-time sequence detector.
package seq_det_pkg;

    // Controller states: waiting for a command, detecting, or parked after a one-shot match.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int DEF_SYM_W   = 3;
    localparam int DEF_SEQ_LEN = 8;
    localparam int DEF_TIMEOUT = 16;

    // Slot i sits at bits [3*i +: 3]; slot 0 is the oldest symbol of the pattern.
    // Slots 0..7 = 001,101,110,000,110,110,011,101.
    localparam logic [DEF_SEQ_LEN*DEF_SYM_W-1:0] SEQ_DEFAULT_PATTERN = {
        3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001
    };

endpackage

// File: rtl/seq_window_matcher.sv
// Symbol shift window with fill tracking and a combinational comparator that
// evaluates the window as it will look after the current shift.
module seq_window_matcher
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift,
    input  logic                     flush,
    input  logic [SYM_W-1:0]         data_in,
    input  logic [SEQ_LEN*SYM_W-1:0] pattern,
    output logic                     match
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);

    logic [SYM_W-1:0]         r_window [SEQ_LEN];
    logic [FILL_W-1:0]        r_fill;
    logic [SEQ_LEN*SYM_W-1:0] w_next_window;
    logic                     w_full_next;

    // Post-shift view: older symbols move down one slot, the new symbol lands in the top slot.
    always_comb begin
        w_next_window = '0;
        for (int i = 0; i < SEQ_LEN - 1; i++) begin
            w_next_window[i*SYM_W +: SYM_W] = r_window[i+1];
        end
        w_next_window[(SEQ_LEN-1)*SYM_W +: SYM_W] = data_in;
        w_full_next = (r_fill >= FILL_W'(SEQ_LEN - 1));
        match       = shift && !flush && w_full_next && (w_next_window == pattern);
    end

    // Window contents need no reset: the fill count decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (shift && !flush) begin
            for (int i = 0; i < SEQ_LEN - 1; i++) begin
                r_window[i] <= r_window[i+1];
            end
            r_window[SEQ_LEN-1] <= data_in;
        end
    end

    // Fill count of valid symbols in the window, saturating at the window depth.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_fill <= '0;
        end else if (shift && (r_fill != FILL_W'(SEQ_LEN))) begin
            r_fill <= r_fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/sequence_detector_ctrl.sv
// Run-time sequence detector controller: programmable pattern, arm/disarm,
// idle-timeout flush, saturating match counter and one-shot mode.
module sequence_detector_ctrl
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [$clog2(SEQ_LEN)-1:0] cfg_idx,
    input  logic [SYM_W-1:0]           cfg_sym,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       one_shot,
    input  logic                       data_valid,
    input  logic [SYM_W-1:0]           data_in,
    output logic                       armed,
    output logic                       done,
    output logic                       sequence_found,
    output logic                       timeout_pulse,
    output logic [CNT_W-1:0]           match_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [SEQ_LEN*SYM_W-1:0] PATTERN_RST = (SEQ_LEN*SYM_W)'(SEQ_DEFAULT_PATTERN);

    seq_state_t               r_state;
    seq_state_t               w_state_next;
    logic [SYM_W-1:0]         r_pattern [SEQ_LEN];
    logic [SEQ_LEN*SYM_W-1:0] w_pattern_flat;
    logic [IDLE_W-1:0]        r_idle;
    logic [CNT_W-1:0]         r_count;
    logic                     r_one_shot;
    logic                     r_armed;
    logic                     r_done;
    logic                     r_found;
    logic                     r_timeout;
    logic                     w_start_ok;
    logic                     w_shift;
    logic                     w_timeout;
    logic                     w_flush;
    logic                     w_match;

    // stop always wins over start; start is only meaningful outside RUN.
    assign w_start_ok = start && !stop && (r_state != RUN);
    assign w_shift    = (r_state == RUN) && data_valid && !stop;
    assign w_timeout  = (r_state == RUN) && !data_valid && !stop &&
                        (r_idle == IDLE_W'(TIMEOUT - 1));
    assign w_flush    = stop || w_timeout || w_start_ok;

    // Flatten the pattern registers for the comparator.
    always_comb begin
        w_pattern_flat = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            w_pattern_flat[i*SYM_W +: SYM_W] = r_pattern[i];
        end
    end

    seq_window_matcher #(
        .SYM_W   (SYM_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_matcher (
        .clk     (clk),
        .reset   (reset),
        .shift   (w_shift),
        .flush   (w_flush),
        .data_in (data_in),
        .pattern (w_pattern_flat),
        .match   (w_match)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = RUN;
            RUN: begin
                if (stop)                       w_state_next = IDLE;
                else if (w_match && r_one_shot) w_state_next = DONE;
            end
            DONE: begin
                if (stop)       w_state_next = IDLE;
                else if (start) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Registered status outputs, decoded from the next state so they track it with one cycle latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            r_found   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_armed   <= (w_state_next == RUN);
            r_done    <= (w_state_next == DONE);
            r_found   <= w_match;
            r_timeout <= w_timeout;
        end
    end

    // Match counter: cleared by an accepted start, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_count <= '0;
        end else if (w_match && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // One-shot mode is captured only when detection is armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_one_shot <= 1'b0;
        end else if (w_start_ok) begin
            r_one_shot <= one_shot;
        end
    end

    // Consecutive idle-cycle counter for the partial-match flush.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok || stop || w_timeout || data_valid) begin
            r_idle <= '0;
        end else if (r_state == RUN) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // Pattern slots are writable only while idle so a running match never sees a torn pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                r_pattern[i] <= PATTERN_RST[i*SYM_W +: SYM_W];
            end
        end else if ((r_state == IDLE) && cfg_we) begin
            r_pattern[cfg_idx] <= cfg_sym;
        end
    end

    assign armed          = r_armed;
    assign done           = r_done;
    assign sequence_found = r_found;
    assign timeout_pulse  = r_timeout;
    assign match_count    = r_count;

endmodule

// File: tb/tb_sequence_detector_ctrl.sv
// Self-checking bench for sequence_detector_ctrl: table-driven first match,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_sequence_detector_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset, cfg_we, start, stop, one_shot, data_valid;
    logic [2:0] cfg_idx, cfg_sym, data_in;
    logic       armed, done, sequence_found, timeout_pulse;
    logic [7:0] match_count;

    always #5 clk = ~clk;

    sequence_detector_ctrl #(
        .SYM_W   (3),
        .SEQ_LEN (8),
        .CNT_W   (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_sym        (cfg_sym),
        .start          (start),
        .stop           (stop),
        .one_shot       (one_shot),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .armed          (armed),
        .done           (done),
        .sequence_found (sequence_found),
        .timeout_pulse  (timeout_pulse),
        .match_count    (match_count)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;
    int   n_tp    = 0;
    int   cyc     = 0;
    int   pulse_cyc[$];
    bit   chk_model = 1'b0;
    logic [2:0] good[8];

    // Reference model: history of accepted symbols since the last flush.
    bit         m_armed, m_done, m_found, m_tp, m_oneshot;
    int         m_cnt, m_idle;
    logic [2:0] m_pat[8];
    logic [2:0] m_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_done = 0; m_found = 0; m_tp = 0; m_oneshot = 0;
        m_cnt = 0; m_idle = 0;
        m_hist.delete();
        m_pat = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};
    endtask

    function automatic bit hist_matches();
        if (m_hist.size() != 8) return 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_hist[i] !== m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        bit was_idle;
        m_found = 0;
        m_tp    = 0;
        if (reset) begin
            model_reset();
            return;
        end
        was_idle = !m_armed && !m_done;
        if (was_idle && cfg_we) m_pat[cfg_idx] = cfg_sym;
        if (m_armed) begin
            if (stop) begin
                m_armed = 0;
                m_hist.delete();
            end else if (data_valid) begin
                m_idle = 0;
                m_hist.push_back(data_in);
                if (m_hist.size() > 8) void'(m_hist.pop_front());
                if (hist_matches()) begin
                    m_found = 1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_oneshot) begin
                        m_armed = 0;
                        m_done  = 1;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_idle = 0;
                    m_hist.delete();
                    m_tp = 1;
                end
            end
        end else if (stop) begin
            m_done = 0;
            m_hist.delete();
        end else if (start) begin
            m_armed   = 1;
            m_done    = 0;
            m_hist.delete();
            m_idle    = 0;
            m_cnt     = 0;
            m_oneshot = one_shot;
        end
    endtask

    task automatic compare_model();
        chk("model_found",  sequence_found, m_found);
        chk("model_armed",  armed,          m_armed);
        chk("model_done",   done,           m_done);
        chk("model_tpulse", timeout_pulse,  m_tp);
        chk("model_count",  match_count,    m_cnt);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (sequence_found === 1'b1) begin
            n_pulse++;
            pulse_cyc.push_back(cyc);
        end
        if (timeout_pulse === 1'b1) n_tp++;
        if (chk_model) compare_model();
    endtask

    task automatic send(input logic [2:0] s);
        data_valid = 1'b1;
        data_in    = s;
        cycle();
        data_valid = 1'b0;
    endtask

    task automatic send_good();
        for (int i = 0; i < 8; i++) send(good[i]);
    endtask

    task automatic do_start(input bit os);
        start    = 1'b1;
        one_shot = os;
        cycle();
        start    = 1'b0;
        one_shot = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic       dv;
        logic [2:0] din;
        logic       e_found;
        logic       e_armed;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs after each edge: {start, dv, din} -> outputs after that edge
        tbl[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 8'd0};
        tbl[5] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 8'd0};
        tbl[6] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 8'd0};
        tbl[7] = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 8'd0};
        tbl[8] = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 8'd1};
        tbl[9] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'd1};
        good   = '{3'd1, 3'd5, 3'd6, 3'd0, 3'd6, 3'd6, 3'd3, 3'd5};

        reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sym = '0;
        start = 1'b0; stop = 1'b0; one_shot = 1'b0; data_valid = 1'b0; data_in = '0;
        model_reset();
        repeat (2) cycle();
        chk("rst_armed", armed, 0);
        chk("rst_done",  done, 0);
        chk("rst_found", sequence_found, 0);
        chk("rst_tp",    timeout_pulse, 0);
        chk("rst_count", match_count, 0);
        reset = 1'b0;

        // Default pattern, one match with latency 1.
        for (int i = 0; i < 10; i++) begin
            start      = tbl[i].start;
            data_valid = tbl[i].dv;
            data_in    = tbl[i].din;
            cycle();
            chk($sformatf("tbl%0d_found", i), sequence_found, tbl[i].e_found);
            chk($sformatf("tbl%0d_armed", i), armed,          tbl[i].e_armed);
            chk($sformatf("tbl%0d_count", i), match_count,    tbl[i].e_cnt);
        end
        start = 1'b0; data_valid = 1'b0;
        chk_model = 1'b1;

        // Broken sequence, then two back-to-back good ones.
        do_stop();
        do_start(0);
        n_pulse = 0; pulse_cyc.delete();
        send(3'd1); send(3'd5); send(3'd6); send(3'd0);
        send(3'd6); send(3'd6); send(3'd3); send(3'd4);
        chk("broken_pulses", n_pulse, 0);
        send_good();
        send_good();
        chk("b2b_pulses", n_pulse, 2);
        chk("b2b_spacing", (pulse_cyc.size() >= 2) ? (pulse_cyc[1] - pulse_cyc[0]) : -1, 8);
        chk("b2b_count", match_count, 2);
        chk("b2b_armed", armed, 1);

        // All-111 pattern: overlapping matches; writes in RUN are ignored.
        do_stop();
        cfg_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_idx = 3'(i);
            cfg_sym = 3'd7;
            cycle();
        end
        cfg_we = 1'b0;
        do_start(0);
        n_pulse = 0;
        repeat (10) send(3'd7);
        chk("overlap_pulses", n_pulse, 3);
        chk("overlap_count", match_count, 3);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_sym = 3'd0;
        cycle();
        cfg_we = 1'b0;
        send(3'd7);
        chk("run_write_ignored", n_pulse, 4);

        // One-shot after reset restores the default pattern.
        do_reset();
        do_start(1);
        n_pulse = 0;
        send_good();
        send_good();
        chk("oneshot_pulses", n_pulse, 1);
        chk("oneshot_done", done, 1);
        chk("oneshot_armed", armed, 0);
        chk("oneshot_count", match_count, 1);
        do_stop();
        chk("stop_done", done, 0);
        chk("stop_armed", armed, 0);
        chk("stop_count_kept", match_count, 1);

        // Idle timeout flushes a partial match.
        do_start(0);
        n_pulse = 0; n_tp = 0;
        for (int i = 0; i < 4; i++) send(good[i]);
        repeat (TIMEOUT - 1) cycle();
        chk("tp_early", timeout_pulse, 0);
        cycle();
        chk("tp_at_timeout", timeout_pulse, 1);
        for (int i = 4; i < 8; i++) send(good[i]);
        chk("tp_once", n_tp, 1);
        chk("tp_no_match", n_pulse, 0);
        chk("tp_armed", armed, 1);
        send_good();
        chk("after_tp_match", n_pulse, 1);

        // Reset mid-sequence; start+stop together stays idle.
        do_start(0);
        n_pulse = 0;
        for (int i = 0; i < 5; i++) send(good[i]);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midrst_armed", armed, 0);
        chk("midrst_done",  done, 0);
        chk("midrst_found", sequence_found, 0);
        chk("midrst_tp",    timeout_pulse, 0);
        chk("midrst_count", match_count, 0);
        for (int i = 5; i < 8; i++) send(good[i]);
        chk("midrst_no_pulse", n_pulse, 0);
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", armed, 0);

        // Randomized traffic with a binary pattern so matches actually occur.
        do_reset();
        cfg_we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_idx = 3'(i);
            cfg_sym = 3'($urandom_range(0, 1));
            cycle();
        end
        cfg_we = 1'b0;
        do_start(0);
        begin
            int gap = 0;
            for (int n = 0; n < 4000; n++) begin
                int r = $urandom_range(0, 999);
                reset    = (r < 1);
                start    = (r >= 1 && r < 20);
                stop     = (r >= 20 && r < 30);
                one_shot = 1'($urandom_range(0, 1));
                cfg_we   = ($urandom_range(0, 19) == 0);
                cfg_idx  = 3'($urandom_range(0, 7));
                cfg_sym  = 3'($urandom_range(0, 1));
                if (gap > 0) begin
                    data_valid = 1'b0;
                    gap--;
                end else begin
                    data_valid = ($urandom_range(0, 9) < 8);
                    if ($urandom_range(0, 149) == 0) gap = $urandom_range(8, 20);
                end
                data_in = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7))
                                                       : 3'($urandom_range(0, 1));
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_detector_ctrl.md
# sequence_detector_ctrl

Run-time controller for 3-bit symbol sequence detection: holds a programmable 8-symbol target pattern and arms/disarms detection on command. It gates the input stream with a data-valid qualifier, flushes partial matches on inactivity timeout, and counts matches, including a one-shot mode. It sits between the stream source and the consumer of `sequence_found`, replacing a fixed-pattern, always-on detector.

## Interface
- `SYM_W`, 3, symbol width in bits
- `SEQ_LEN`, 8, pattern length in symbols (index width `IDX_W = $clog2(SEQ_LEN)`)
- `CNT_W`, 8, match counter width
- `TIMEOUT`, 16, idle cycles (no `data_valid`) in RUN before the partial match is flushed; at least 1
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `cfg_we` in 1: pattern write strobe
- `cfg_idx` in IDX_W: pattern slot to write (0 = oldest/first symbol)
- `cfg_sym` in SYM_W: symbol value written
- `start` in 1: arm detection
- `stop` in 1: disarm and flush
- `one_shot` in 1: sampled on accepted `start`; 1 = stop after first match
- `data_valid` in 1: qualifies `data_in`
- `data_in` in SYM_W: input symbol
- `armed` out 1: high in RUN
- `done` out 1: high in DONE
- `sequence_found` out 1: one-cycle match pulse
- `timeout_pulse` out 1: one-cycle flush-on-idle pulse
- `match_count` out CNT_W: matches since last accepted `start`, saturating

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. All outputs 0, `match_count` 0, window fill 0, idle counter 0. Pattern slots 0..7 = 001,101,110,000,110,110,011,101.
- IDLE:
  - `cfg_we` writes `cfg_sym` to slot `cfg_idx`. `cfg_we` is ignored in RUN and DONE.
  - `data_valid` is ignored.
  - `start` (without `stop`) goes to RUN: clears fill, idle counter and `match_count`; latches `one_shot`.
- RUN:
  - Each `data_valid` cycle shifts `data_in` into an SEQ_LEN-deep window and increments fill (saturating at SEQ_LEN).
  - Match: post-shift fill == SEQ_LEN and window[i] == pattern[i] for all i, where window[0] is the oldest symbol.
  - On a match, pulse `sequence_found` and increment `match_count` (holds at all-ones).
  - The window is not cleared on a match, so overlapping occurrences are detected (a periodic pattern can match on consecutive symbols).
  - If latched `one_shot` = 1, a match moves the block to DONE.
- Timeout:
  - The idle counter increments each RUN cycle without `data_valid` and clears on `data_valid`.
  - When it reaches TIMEOUT: fill <= 0, counter <= 0, `timeout_pulse` for one cycle; the block stays in RUN.
- `stop` in RUN or DONE goes to IDLE and flushes fill. `match_count` is retained until the next `start`.
- DONE:
  - `start` re-arms to RUN, with the same clearing as from IDLE.
  - `data_valid` is ignored.
- Simultaneous events:
  - `stop` beats `start`.
  - In RUN, `stop` with a matching symbol: the match is not reported and the state goes to IDLE.
  - A match and a timeout cannot coincide, because a match cycle has `data_valid`.
  - `reset` overrides everything, including mid-sequence; the pattern returns to its default.

## Timing
- All outputs are registered.
- `sequence_found` is high in the cycle after the edge that samples the final matching symbol (latency 1). `match_count` updates on that same edge.
- `armed` and `done` change one cycle after the sampled `start`, `stop` or match.
- A pattern written by `cfg_we` is used from the first RUN cycle after it.
- `timeout_pulse` is high the cycle after the TIMEOUT-th consecutive idle cycle.
- Throughput: one symbol per clock; no backpressure.

## Structure
- Package `seq_det_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE}
  - default pattern constant `SEQ_DEFAULT_PATTERN` (8 x 3-bit)
  - default `SYM_W`, `SEQ_LEN` and `TIMEOUT` constants
- Sub-module `seq_window_matcher`: shift window, fill counter and comparator. Inputs are shift, flush, `data_in` and the pattern vector; output is a combinational `match`.
- Top level holds the FSM, pattern registers, idle counter and match counter.

## Test plan
- Default pattern; `start` with `one_shot`=0; symbols 001,101,110,000,110,110,011,101 with `data_valid` -> one `sequence_found` pulse one cycle after the last symbol; `match_count`=1; `armed` stays 1.
- Same sequence ending in 100, then two back-to-back correct sequences -> no pulse for the broken sequence; two pulses 8 cycles apart; `match_count`=2.
- Write pattern 111 x 8 in IDLE; RUN; 10 consecutive 111 symbols -> pulses on symbols 8, 9 and 10 (overlap); `match_count`=3. A `cfg_we` attempted in RUN leaves the pattern unchanged.
- `one_shot`=1; correct sequence, then a second correct sequence -> exactly one pulse; `done`=1, `armed`=0; `match_count`=1; `stop` -> IDLE.
- Send 4 correct symbols, hold `data_valid`=0 for TIMEOUT cycles, send the remaining 4 -> `timeout_pulse` once, no match; a full sequence afterwards matches.
- `reset` asserted after 5 symbols in RUN -> next cycle all outputs 0, state IDLE; the remaining 3 symbols produce no pulse; `start` with `stop` together -> stays IDLE.
